// File: rtl/tile_palette_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tile_palette_arbiter
// Purpose  : Round-robin arbiter that shares one combinational 16-entry tile
//            palette between N_REQ pixel requesters. At most one requester is
//            granted per cycle. The palette colour for the winner's index is
//            registered and returned to that requester one cycle later, with
//            a transparency flag for index 0.
// Ports    :
//   clk_i             system clock, rising edge
//   reset_i           synchronous active-high reset
//   lookup_en_i       global enable; low blocks all grants
//   req_valid_i       per-requester pending lookup
//   req_index_i       per-requester 4-bit palette index, requester i at [4i+3:4i]
//   req_ready_o       one-hot grant (combinational)
//   pal_index_o       index driven to the shared palette (0 when no grant)
//   pal_red/green/blue_i  palette colour for pal_index_o (same cycle)
//   rsp_valid_o       one-hot registered response marker
//   rsp_red/green/blue_o  registered colour of the last granted lookup
//   rsp_transparent_o registered; set when the granted index was 0
// Revision : 1.0 - initial release
// ============================================================================
module tile_palette_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               lookup_en_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [4*N_REQ-1:0] req_index_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [3:0]         pal_index_o,
  input  logic [3:0]         pal_red_i,
  input  logic [3:0]         pal_green_i,
  input  logic [3:0]         pal_blue_i,
  output logic [N_REQ-1:0]   rsp_valid_o,
  output logic [3:0]         rsp_red_o,
  output logic [3:0]         rsp_green_o,
  output logic [3:0]         rsp_blue_o,
  output logic               rsp_transparent_o
);

  // N_REQ widened by one bit so wrap arithmetic never overflows.
  localparam logic [PTR_W:0] NREQ_EXT = (PTR_W+1)'(N_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [11:0]      rsp_rgb_q, rsp_rgb_d;
  logic             rsp_transp_q, rsp_transp_d;

  logic             grant_valid;
  logic [PTR_W-1:0] win;
  logic [PTR_W:0]   cand;
  logic [PTR_W:0]   win_inc;

  // Scan from ptr upward, wrapping at N_REQ; first valid requester wins.
  always_comb begin
    grant_valid = 1'b0;
    win         = '0;
    cand        = '0;
    req_ready_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= NREQ_EXT) begin
        cand = cand - NREQ_EXT;
      end
      if (lookup_en_i && !grant_valid && req_valid_i[cand[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        win         = cand[PTR_W-1:0];
      end
    end
    if (grant_valid) begin
      req_ready_o[win] = 1'b1;
    end
  end

  assign pal_index_o = grant_valid ? req_index_i[{win, 2'b00} +: 4] : 4'd0;

  // Next-state: the pointer moves past the winner; colour/transparency only
  // update on a grant, while rsp_valid pulses for exactly one cycle.
  always_comb begin
    ptr_d        = ptr_q;
    rsp_valid_d  = '0;
    rsp_rgb_d    = rsp_rgb_q;
    rsp_transp_d = rsp_transp_q;
    win_inc      = {1'b0, win} + 1'b1;
    if (grant_valid) begin
      ptr_d        = (win_inc == NREQ_EXT) ? '0 : win_inc[PTR_W-1:0];
      rsp_valid_d  = req_ready_o;
      rsp_rgb_d    = {pal_red_i, pal_green_i, pal_blue_i};
      rsp_transp_d = (pal_index_o == 4'd0);
    end
  end

  // Reset discards any grant presented in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rgb_q    <= '0;
      rsp_transp_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rgb_q    <= rsp_rgb_d;
      rsp_transp_q <= rsp_transp_d;
    end
  end

  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_red_o         = rsp_rgb_q[11:8];
  assign rsp_green_o       = rsp_rgb_q[7:4];
  assign rsp_blue_o        = rsp_rgb_q[3:0];
  assign rsp_transparent_o = rsp_transp_q;

endmodule
`default_nettype wire

// File: doc/tile_palette_arbiter.md
# tile_palette_arbiter

Shares one combinational 16-entry, 4-bit-index tile palette (12-bit RGB out) between several pixel requesters, e.g. background tile, foreground tile and sprite layers, which need colour lookups in the same pixel window. Each cycle it grants at most one requester by round-robin. It drives the winner's index to the palette and registers the returned colour. The response reaches the winning requester one cycle later, with a transparency flag for index 0.

## Interface
- N_REQ, default 4, number of requesters (2..8)
- PTR_W, default 2, width of the round-robin pointer, $clog2(N_REQ)
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- lookup_en  in  1  global enable; low means no grants this cycle
- req_valid  in  N_REQ  bit i: requester i has a pending lookup
- req_index  in  4*N_REQ  requester i index at bits [4i+3:4i]
- req_ready  out  N_REQ  one-hot grant, combinational, same cycle as acceptance
- pal_index  out  4  index to shared palette (combinational from winner)
- pal_red, pal_green, pal_blue  in  4 each  palette output for pal_index (combinational, same cycle)
- rsp_valid  out  N_REQ  one-hot, registered; bit i marks the response for requester i
- rsp_red, rsp_green, rsp_blue  out  4 each  registered colour of the last granted lookup
- rsp_transparent  out  1  registered; 1 when the granted index was 0

## Operation
- Handshake: a transfer occurs on requester i when req_valid[i] && req_ready[i]. The requester holds req_valid and req_index stable until ready. Deasserting valid before grant is allowed, and no transfer occurs.
- Arbitration, when lookup_en=1:
  - Scan requesters starting at pointer ptr, ascending modulo N_REQ.
  - The first i with req_valid[i]=1 wins and gets req_ready[i]=1. All other ready bits are 0.
- After a grant to i: ptr <= (i+1) mod N_REQ.
- No grant: this covers lookup_en=0 or no valid requests.
  - ptr is unchanged.
  - req_ready=0.
  - pal_index=0.
- pal_index equals req_index of the winner.
- On each grant edge:
  - rsp_valid <= one-hot(i).
  - {rsp_red,rsp_green,rsp_blue} <= {pal_red,pal_green,pal_blue}.
  - rsp_transparent <= (winner index == 0).
- On a cycle with no grant: rsp_valid <= 0. Colour and transparent registers hold their values.
- Index 0 still does a palette read and returns its colour. rsp_transparent tells the consumer to skip the pixel.
- A requester granted back-to-back gets one response per grant, in order.
- Reset (Clk edge with Reset=1):
  - ptr=0.
  - rsp_valid=0, rsp_red/green/blue=0, rsp_transparent=0.
  - Any grant asserted in that cycle is discarded: no response follows.
  - Reset dominates lookup_en.

## Timing
- Grant to response latency: exactly 1 cycle. A grant at edge k gives a response visible after edge k+1, held for one cycle.
- Throughput: one lookup per cycle total. Each requester is served at least once every N_REQ granted cycles while its valid is held.
- Combinational path: req_valid/ptr/lookup_en, then grant, then pal_index, then external palette, then the rsp registers. This must close within one Clk period.
- Outputs after reset: req_ready is combinational and 0 if no valid. All registered outputs are 0.

## Test plan
The bench palette model maps index 0 to {0,0,0}, 1 to {F,A,3}, 5 to {8,6,0}, 8 to {3,1,0}, and all others to {F,B,3}.
- Reset, then all four requesters valid continuously with indices 1,5,8,2 -> grants cycle 0,1,2,3,0,... One per cycle. Responses one cycle later: req0 {F,A,3}, req1 {8,6,0}, req2 {3,1,0}, req3 {F,B,3}.
- Only req2 valid, index 0 -> req_ready=0100 every cycle. rsp_valid=0100 each following cycle, colour {0,0,0}, rsp_transparent=1.
- All valid with lookup_en=0 for 3 cycles -> req_ready=0 and rsp_valid=0 throughout. ptr unchanged, so the first grant after lookup_en=1 goes to the requester after the last winner.
- ptr=3 (after a grant to req2), then req0 and req3 valid -> req3 granted first, then req0. ptr wraps to 0 after the req3 grant, then to 1 after the req0 grant.
- Reset asserted on the cycle req1 is granted -> no rsp_valid next cycle. ptr=0. All rsp outputs 0. Normal arbitration resumes on the first cycle with Reset=0.
- Random valid/index pattern over 10k cycles against a reference model -> every transfer gets exactly one response with the correct one-hot bit and colour. No requester waits more than N_REQ-1 granted cycles while held valid.
